camera_view_controller: RTL and testbench

Turns the player's left/right turn buttons into the 3-bit `camera_view` code consumed by the rendering controller. The block selects which background and enemy flag the renderer uses. It sequences Forward, Left and Right through timed transitional states (FtoL, LtoF, FtoR, RtoF) so the renderer and enemy logic see a clean, glitch-free view code. It sits between the board button pins and the rendering/enemy logic, in the same clock domain as the renderer.

---
 rtl/camera_pkg.sv | 28 ++
 rtl/button_debouncer.sv | 58 +++++
 rtl/camera_view_controller.sv | 113 +++++++++++
 tb/tb_camera_view_controller.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared view-code definitions used by the camera controller, renderer and enemy logic.
package camera_pkg;

  localparam logic [2:0] VIEW_FORWARD = 3'b001;
  localparam logic [2:0] VIEW_FTOL    = 3'b010;
  localparam logic [2:0] VIEW_LEFT    = 3'b011;
  localparam logic [2:0] VIEW_LTOF    = 3'b100;
  localparam logic [2:0] VIEW_FTOR    = 3'b101;
  localparam logic [2:0] VIEW_RIGHT   = 3'b110;
  localparam logic [2:0] VIEW_RTOF    = 3'b111;

  // State encoding equals the view code so the state register drives the output directly.
  typedef enum logic [2:0] {
    ST_ILLEGAL = 3'b000,
    ST_FORWARD = VIEW_FORWARD,
    ST_FTOL    = VIEW_FTOL,
    ST_LEFT    = VIEW_LEFT,
    ST_LTOF    = VIEW_LTOF,
    ST_FTOR    = VIEW_FTOR,
    ST_RIGHT   = VIEW_RIGHT,
    ST_RTOF    = VIEW_RTOF
  } view_state_e;

  function automatic logic is_transitional(input view_state_e s);
    return (s == ST_FTOL) || (s == ST_LTOF) || (s == ST_FTOR) || (s == ST_RTOF);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw push button, debounces it, and emits a one-cycle pulse on each accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // Count consecutive cycles the synced level disagrees with the accepted level; flip once it has held long enough.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer, counter, accepted level and press pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/camera_view_controller.sv
// View FSM: turns debounced left/right presses into timed Forward/Left/Right camera view codes.
module camera_view_controller
  import camera_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TURN_CYCLES     = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       game_active,
  output logic [2:0] camera_view,
  output logic       turning,
  output logic       turn_done
);

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0] DWELL_LAST = TW'(TURN_CYCLES - 1);

  logic [1:0]    unused_levels;
  logic          press_left, press_right;
  view_state_e   state_q, state_d;
  logic [TW-1:0] dwell_q, dwell_d;
  logic          turning_q, turning_d;
  logic          turn_done_q, turn_done_d;
  logic          go_left, go_right;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_left),
    .level  (unused_levels[0]),
    .press  (press_left)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_right),
    .level  (unused_levels[1]),
    .press  (press_right)
  );

  // Simultaneous presses cancel each other so an ambiguous input never moves the camera.
  assign go_left  = press_left  & ~press_right;
  assign go_right = press_right & ~press_left;

  // Next view, dwell count and turn-complete pulse; stable views react only to presses, transitional views only to the dwell.
  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    turn_done_d = 1'b0;
    if (!game_active) begin
      state_d = ST_FORWARD;
      dwell_d = '0;
    end else begin
      case (state_q)
        ST_FORWARD: begin
          dwell_d = '0;
          if (go_left)       state_d = ST_FTOL;
          else if (go_right) state_d = ST_FTOR;
        end
        ST_LEFT: begin
          dwell_d = '0;
          if (go_right) state_d = ST_LTOF;
        end
        ST_RIGHT: begin
          dwell_d = '0;
          if (go_left) state_d = ST_RTOF;
        end
        ST_FTOL, ST_LTOF, ST_FTOR, ST_RTOF: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d     = '0;
            turn_done_d = 1'b1;
            case (state_q)
              ST_FTOL: state_d = ST_LEFT;
              ST_FTOR: state_d = ST_RIGHT;
              default: state_d = ST_FORWARD;
            endcase
          end else begin
            dwell_d = dwell_q + TW'(1);
          end
        end
        default: begin
          state_d = ST_FORWARD;
          dwell_d = '0;
        end
      endcase
    end
    turning_d = is_transitional(state_d);
  end

  // State, dwell counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FORWARD;
      dwell_q     <= '0;
      turning_q   <= 1'b0;
      turn_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      turning_q   <= turning_d;
      turn_done_q <= turn_done_d;
    end
  end

  assign camera_view = state_q;
  assign turning     = turning_q;
  assign turn_done   = turn_done_q;

endmodule

// File: tb/tb_camera_view_controller.sv
// Directed bench for camera_view_controller with short debounce and dwell times.
module tb_camera_view_controller;

  logic       clk;
  logic       rst_n;
  logic       btn_left;
  logic       btn_right;
  logic       game_active;
  logic [2:0] camera_view;
  logic       turning;
  logic       turn_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       l;
    logic       r;
    logic       ga;
    logic [7:0] cycles;
    logic [2:0] view;
    logic       turning;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  camera_view_controller #(.DEBOUNCE_CYCLES(4), .TURN_CYCLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .game_active(game_active),
    .camera_view(camera_view),
    .turning    (turning),
    .turn_done  (turn_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the inputs just after an edge, then advance to 1 time unit past the next rising edge.
  task automatic applyStimulus(input logic l, input logic r, input logic ga);
    btn_left    = l;
    btn_right   = r;
    game_active = ga;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [2:0] ev, input logic et, input logic ed);
    checks++;
    if (camera_view !== ev || turning !== et || turn_done !== ed) begin
      errors++;
      $display("[TB] FAIL %s #%0d view/turning/done got %b/%b/%b want %b/%b/%b",
               name, idx, camera_view, turning, turn_done, ev, et, ed);
    end
  endtask

  function automatic vec_t mk(input logic l, input logic r, input logic ga, input int n,
                              input logic [2:0] v, input logic t, input logic d);
    vec_t x;
    x.l = l; x.r = r; x.ga = ga; x.cycles = 8'(n);
    x.view = v; x.turning = t; x.done = d;
    return x;
  endfunction

  initial begin
    int step;
    btn_left    = 1'b0;
    btn_right   = 1'b0;
    game_active = 1'b1;
    rst_n       = 1'b1;

    // Idle, then a left turn with the button held from the first cycle.
    vecs.push_back(mk(0, 0, 1, 5, 3'b001, 0, 0));
    vecs.push_back(mk(1, 0, 1, 6, 3'b001, 0, 0));
    vecs.push_back(mk(1, 0, 1, 8, 3'b010, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 3'b011, 0, 1));
    vecs.push_back(mk(1, 0, 1, 3, 3'b011, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8, 3'b011, 0, 0));
    // Left press while already Left does nothing.
    vecs.push_back(mk(1, 0, 1, 10, 3'b011, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8, 3'b011, 0, 0));
    // Right press from Left returns Forward through LtoF.
    vecs.push_back(mk(0, 1, 1, 6, 3'b011, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8, 3'b100, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 3'b001, 0, 1));
    vecs.push_back(mk(0, 1, 1, 2, 3'b001, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8, 3'b001, 0, 0));
    // Three-cycle glitch is rejected.
    vecs.push_back(mk(1, 0, 1, 3, 3'b001, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8, 3'b001, 0, 0));
    // Both buttons together are ignored.
    vecs.push_back(mk(1, 1, 1, 10, 3'b001, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8, 3'b001, 0, 0));
    // FtoR with a debounced left press during the dwell.
    vecs.push_back(mk(0, 1, 1, 6, 3'b001, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 3'b101, 1, 0));
    vecs.push_back(mk(1, 1, 1, 6, 3'b101, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 3'b101, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 3'b110, 0, 1));
    vecs.push_back(mk(0, 1, 1, 3, 3'b110, 0, 0));
    // Dropping game_active forces Forward without a done pulse.
    vecs.push_back(mk(0, 1, 0, 3, 3'b001, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8, 3'b001, 0, 0));
    // Dropping game_active in the middle of FtoL.
    vecs.push_back(mk(1, 0, 1, 6, 3'b001, 0, 0));
    vecs.push_back(mk(1, 0, 1, 3, 3'b010, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 3'b001, 0, 0));
    vecs.push_back(mk(1, 0, 1, 3, 3'b001, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8, 3'b001, 0, 0));

    // Asynchronous reset takes effect without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", 0, 3'b001, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold", 0, 3'b001, 1'b0, 1'b0);
    rst_n = 1'b1;

    step = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < int'(vecs[i].cycles); c++) begin
        applyStimulus(vecs[i].l, vecs[i].r, vecs[i].ga);
        checkOutput("vec", step, vecs[i].view, vecs[i].turning, vecs[i].done);
        step++;
      end
    end

    // Reset mid-FtoL, with the left button held through reset and release.
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (c < 7) checkOutput("midturn_setup", c, 3'b001, 1'b0, 1'b0);
      else       checkOutput("midturn_setup", c, 3'b010, 1'b1, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midturn_reset", 0, 3'b001, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("midturn_reset_edge", 0, 3'b001, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (c < 7) checkOutput("held_through_reset", c, 3'b001, 1'b0, 1'b0);
      else       checkOutput("held_through_reset", c, 3'b010, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
